regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: write-data width, matching the register width.
REQ-002 Parameter ADDR_W, default 5: register-address width (32 registers).
REQ-003 Parameter CNT_W, default 8: width of the per-requester grant counters.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 a_valid  input  1  requester A has a write pending.
REQ-007 a_addr  input  ADDR_W  requester A target register.
REQ-008 a_data  input  DATA_W  requester A write data.
REQ-009 a_ready  output  1  requester A write accepted this cycle.
REQ-010 b_valid, b_addr, b_data, b_ready: same widths and meaning as the A ports, for requester B.
REQ-011 ctrl_writeEnable  output  1  registered write strobe to the register file.
REQ-012 ctrl_writeReg  output  ADDR_W  registered write address.
REQ-013 data_writeReg  output  DATA_W  registered write data.
REQ-014 a_count, b_count  output  CNT_W  saturating count of accepted writes per requester.

Function
REQ-015 The block SHALL accept at most one request per cycle, with acceptance defined as x_valid && x_ready.
REQ-016 x_ready SHALL be combinational from the valid inputs and the arbitration state, with no dependency on any data input.
REQ-017 An accepted write SHALL appear on ctrl_writeEnable, ctrl_writeReg and data_writeReg exactly 1 cycle after acceptance and be held for exactly 1 cycle.
REQ-018 With neither request accepted, ctrl_writeEnable SHALL be 0 in the next cycle, and ctrl_writeReg and data_writeReg SHALL hold their previous values.
REQ-019 An accepted write with address 0 SHALL be consumed (ready=1, counter incremented) while ctrl_writeEnable stays 0, because register 0 is hard-wired to zero.
REQ-020 Arbitration state SHALL be a 1-bit last_grant flag with states LAST_A and LAST_B.
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the requester that is not last_grant.
  - After each grant, last_grant SHALL take the granted requester's value.
REQ-021 When both requesters are valid and target the same address, only the granted write SHALL issue that cycle; the loser stays pending and issues on a later cycle, so the loser's data is the final value.
REQ-022 A requester that has not been granted SHALL keep valid asserted with stable address and data until accepted; the block SHALL NOT buffer unaccepted requests.
REQ-023 a_count and b_count SHALL increment by 1 per accepted write of their requester and saturate at 2^CNT_W-1 with no wrap-around.
REQ-024 Under continuous dual requests, grants SHALL alternate A,B,A,B..., giving each requester 50% of cycles and starvation of no more than 1 cycle.

Reset
REQ-025 Asserting reset (low) SHALL immediately clear all of the following, independent of clock:
  - ctrl_writeEnable=0
  - ctrl_writeReg=0
  - data_writeReg=0
  - a_count=0 and b_count=0
  - last_grant=LAST_B, so A wins the first contention.
REQ-026 While reset is low, a_ready and b_ready SHALL be 0.
REQ-027 A write accepted in the cycle reset asserts SHALL be discarded, and no write strobe SHALL follow.
REQ-028 The first acceptance SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro REGFILE_WR_ARB_RR_EN SHALL select the arbitration policy.
REQ-030 With REGFILE_WR_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-020.
REQ-031 Without REGFILE_WR_ARB_RR_EN, arbitration SHALL be fixed priority with A always winning contention.
  - last_grant SHALL be absent.
  - REQ-024 SHALL NOT apply, and B may starve.

Verification
REQ-032 A write, no contention: a_valid=1, a_addr=3, a_data=0xDEADBEEF for one cycle -> a_ready=1; next cycle ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=0xDEADBEEF; a_count=1.
REQ-033 Contention, round-robin: A and B valid with addresses 4/5 held for 4 cycles after reset -> grant order A,B,A,B; a_count=2, b_count=2. With REGFILE_WR_ARB_RR_EN undefined -> grant order A,A,A,A and b_count=0.
REQ-034 Register 0 suppression: b_valid=1, b_addr=0, b_data=0x1 -> b_ready=1, b_count=1; next cycle ctrl_writeEnable=0.
REQ-035 Same-address contention: A writes 0x11 and B writes 0x22 to address 7, both valid -> two strobes to address 7, with B's 0x22 last.
REQ-036 Counter saturation: CNT_W=2, 5 accepted A writes -> a_count sequence 1,2,3,3,3.
REQ-037 Mid-operation reset: reset driven low asynchronously during an accept cycle -> outputs zero immediately and no strobe follows; after release, A beats B on the first contention.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose: merges two register-file write requesters (A and B) onto a single
// registered write port. At most one request is accepted per cycle. The
// accepted write appears on the write port one cycle later for exactly one
// cycle. Writes to register 0 are accepted and counted, but no strobe is
// issued because register 0 is hard-wired to zero.
//
// Configuration macro: REGFILE_WR_ARB_RR_EN
//   defined   -> round-robin arbitration using a 1-bit last_grant flag
//                (reset value LAST_B, so A wins the first contention).
//   undefined -> fixed priority, A always wins contention (B may starve).
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   a_valid/a_addr/a_data   in   requester A write request
//   a_ready          out  requester A accepted this cycle (combinational)
//   b_valid/b_addr/b_data   in   requester B write request
//   b_ready          out  requester B accepted this cycle (combinational)
//   ctrl_writeEnable out  registered write strobe
//   ctrl_writeReg    out  registered write address
//   data_writeReg    out  registered write data
//   a_count/b_count  out  saturating count of accepted writes per requester
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic grant_a;
  logic grant_b;

`ifdef REGFILE_WR_ARB_RR_EN
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_grant_e;

  last_grant_e last_grant_q;
  last_grant_e last_grant_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= LAST_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Grants are gated by reset so nothing is accepted while reset is held.
  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    last_grant_d = last_grant_q;
    if (reset) begin
      if (a_valid && b_valid) begin
        // Contention: the requester that did not win last time goes now.
        if (last_grant_q == LAST_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    if (grant_a) begin
      last_grant_d = LAST_A;
    end else if (grant_b) begin
      last_grant_d = LAST_B;
    end
  end
`else
  // Fixed priority: A always wins, B only goes when A is idle.
  always_comb begin
    grant_a = reset && a_valid;
    grant_b = reset && b_valid && !a_valid;
  end
`endif

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Write port and counters
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] wreg_q,    wreg_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [CNT_W-1:0]  a_count_q, a_count_d;
  logic [CNT_W-1:0]  b_count_q, b_count_d;

  // Address/data only change when a strobe is actually issued; an idle cycle
  // or a register-0 write leaves the previous address/data on the port.
  always_comb begin
    we_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (grant_a) begin
      if (a_count_q != CNT_MAX) begin
        a_count_d = a_count_q + 1'b1;
      end
      if (a_addr != '0) begin
        we_d    = 1'b1;
        wreg_d  = a_addr;
        wdata_d = a_data;
      end
    end else if (grant_b) begin
      if (b_count_q != CNT_MAX) begin
        b_count_d = b_count_q + 1'b1;
      end
      if (b_addr != '0) begin
        we_d    = 1'b1;
        wreg_d  = b_addr;
        wdata_d = b_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign a_count          = a_count_q;
  assign b_count          = b_count_q;

endmodule
